max7219_display_driver: RTL
===========================

Name: max7219_display_driver

Overview:
- Downstream stage of the calculator FSM.
- Takes an 8-digit code-B display image plus a one-cycle update strobe, and serialises it to the MAX7219 over max_sck/max_cs/max_din.
- After reset it runs the MAX7219 initialisation sequence on its own, then refreshes all 8 digit registers on each update.
- Frees the FSM from bit-level SPI timing.

Parameters:
- SCK_DIV, 2: clock cycles per SCK half-period; legal range ≥1.
- INTENSITY, 4'h8: value written to the intensity register (0x0A) during init.

Ports:
- clock  in  1  system clock; one clock domain.
- reset  in  1  synchronous, active-high reset.
- digits  in  32  eight 4-bit code-B values; [3:0] is digit 0 (register 0x01), [31:28] is digit 7 (register 0x08).
- dp_mask  in  8  decimal point per digit; bit i belongs to digit i.
- blank_mask  in  8  1 = digit i is forced to code-B blank (0xF).
- update  in  1  one-cycle request to refresh the display.
- busy  out  1  high while the init sequence or a refresh is in progress.
- init_done  out  1  high once the init sequence has completed; stays high until reset.
- max_sck  out  1  SPI clock; idle low.
- max_cs  out  1  chip select (LOAD); active low.
- max_din  out  1  serial data, MSB first.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high. All outputs are registered.
- Reset values: max_cs=1, max_sck=0, max_din=0, busy=1, init_done=0, pending=0.
- Reset mid-frame: on the next edge max_cs=1 and max_sck=0 (a partial frame is discarded by the device). The init sequence restarts from frame 0.
- Frame format: 16 bits = {4'h0, addr[3:0], data[7:0]}, sent MSB first. The MAX7219 samples DIN on the SCK rising edge and latches the frame on the CS rising edge.
- Frame timing, per-frame FSM TX_IDLE → TX_LOAD → TX_SHIFT → TX_HOLD → TX_GAP:
  - TX_LOAD: 1 cycle; cs←0, din←bit15, sck=0.
  - TX_SHIFT: each bit is SCK_DIV cycles with sck=0, then SCK_DIV cycles with sck=1. din advances to the next bit on the cycle sck returns to 0. Done after bit 0's high phase.
  - TX_HOLD: SCK_DIV cycles; sck=0, cs=0.
  - TX_GAP: 2*SCK_DIV cycles; cs=1.
  - Frame length is 1+35*SCK_DIV cycles (71 at default).
- Sequencer FSM:
  - S_INIT: sends, in order, 0x0C01 (normal operation), 0x09FF (code-B on all digits), 0x0B07 (scan 8 digits), {0x0A, 4'h0, INTENSITY}, 0x0F00 (display test off).
  - After S_INIT: init_done←1 and the FSM goes to S_REFRESH. It always performs one refresh with the current inputs.
  - S_REFRESH: digits, dp_mask and blank_mask are sampled once, at refresh start, into a shadow register. It then sends 8 frames, addr 0x01..0x08, with data = {dp_mask[i], 3'b000, blank_mask[i] ? 4'hF : digits[4i+3:4i]}.
  - S_IDLE: busy=0.
- Update handling:
  - update in S_IDLE: busy←1 on the next cycle; the first frame's TX_LOAD follows that cycle.
  - update while busy: sets a one-deep pending flag; extra updates coalesce. At the end of the current refresh or init, pending clears and a new refresh starts. busy stays high with no idle cycle between them.
  - update in the same cycle the last frame ends: it is treated as pending and serviced.
- Input changes mid-refresh have no effect on the frames in flight.
- Latency:
  - Full refresh = 8*(1+35*SCK_DIV) cycles plus 1 (568+1 at default).
  - Full init = 5 frames.

Decomposition:
- Package max7219_pkg holds:
  - register addresses: REG_DIGIT0=0x1, REG_DECODE=0x9, REG_INTENSITY=0xA, REG_SCANLIM=0xB, REG_SHUTDOWN=0xC, REG_TEST=0xF;
  - code-B constants: CB_DASH=0xA, CB_E=0xB, CB_H=0xC, CB_L=0xD, CB_P=0xE, CB_BLANK=0xF;
  - FRAME_W=16.
- Sub-module max7219_spi_tx handles one frame. Interface: clock, reset, start, frame[15:0], done pulse, and the three pins. The top holds the sequencer, shadow registers and pending logic.

Test Plan:
- Init: release reset, SCK_DIV=2. The bench model captures 5 frames 0x0C01, 0x09FF, 0x0B07, 0x0A08, 0x0F00. init_done rises after the 5th CS rise. 8 digit frames follow. busy falls 1+13*71 cycles after reset release.
- Refresh: digits=32'h76543210, dp_mask=8'h04, blank_mask=8'h80, pulse update in idle. Required frames: 0x0100, 0x0201, 0x0382, 0x0403, 0x0504, 0x0605, 0x0706, 0x080F. Each frame has exactly 16 SCK rises.
- Timing check: SCK_DIV=1 and SCK_DIV=3. SCK high and low phases each equal SCK_DIV cycles. DIN is stable on every SCK rise. CS is high for ≥2*SCK_DIV cycles between frames. sck=0 whenever cs=1.
- Coalescing: pulse update 3 times during a refresh, changing digits each time. Exactly one extra refresh follows, carrying the last digit values, with no busy gap.
- Snapshot: change digits in the middle of frame 3. All 8 frames of that refresh carry the pre-change values.
- Reset mid-frame: assert reset during bit 7 of a digit frame. The next cycle shows cs=1, sck=0, busy=1. The init sequence then restarts from 0x0C01.

Source files
------------

// File: rtl/max7219_pkg.sv
// Shared definitions for the MAX7219 display driver.
// Holds the device register map, code-B glyph values, the frame width,
// the FSM state types and a helper that packs one 16-bit SPI frame.
package max7219_pkg;

   localparam int FRAME_W = 16;

   localparam logic [3:0] REG_DIGIT0    = 4'h1;
   localparam logic [3:0] REG_DECODE    = 4'h9;
   localparam logic [3:0] REG_INTENSITY = 4'hA;
   localparam logic [3:0] REG_SCANLIM   = 4'hB;
   localparam logic [3:0] REG_SHUTDOWN  = 4'hC;
   localparam logic [3:0] REG_TEST      = 4'hF;

   localparam logic [3:0] CB_DASH  = 4'hA;
   localparam logic [3:0] CB_E     = 4'hB;
   localparam logic [3:0] CB_H     = 4'hC;
   localparam logic [3:0] CB_L     = 4'hD;
   localparam logic [3:0] CB_P     = 4'hE;
   localparam logic [3:0] CB_BLANK = 4'hF;

   typedef enum logic [2:0] {TX_IDLE, TX_LOAD, TX_SHIFT, TX_HOLD, TX_GAP} tx_state_t;
   typedef enum logic [1:0] {S_INIT, S_REFRESH, S_IDLE} seq_state_t;

   function automatic logic [FRAME_W-1:0] make_frame(input logic [3:0] addr,
                                                     input logic [7:0] data);
      return {4'h0, addr, data};
   endfunction

endpackage

// File: rtl/max7219_spi_tx.sv
// One-frame SPI transmitter for the MAX7219.
// Ports: clock/reset (sync, active high); start + frame request a frame and
// are accepted while idle or in the last gap cycle (back-to-back frames);
// done is high during the last gap cycle; max_sck/max_cs/max_din are the pins.
//
// state    | meaning
// TX_IDLE  | cs high, waiting for start
// TX_LOAD  | one cycle, cs low, first bit on din
// TX_SHIFT | 16 bits, SCK_DIV cycles low then SCK_DIV cycles high each
// TX_HOLD  | SCK_DIV cycles with cs still low after the last rise
// TX_GAP   | 2*SCK_DIV cycles with cs high; device latches on the cs rise
module max7219_spi_tx
   import max7219_pkg::*;
#(
   parameter int SCK_DIV = 2
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               start,
   input  logic [FRAME_W-1:0] frame,
   output logic               done,
   output logic               max_sck,
   output logic               max_cs,
   output logic               max_din
);

   localparam int CNT_W = $clog2(2*SCK_DIV+1);
   localparam logic [CNT_W-1:0] C_HALF = CNT_W'(SCK_DIV-1);
   localparam logic [CNT_W-1:0] C_GAP  = CNT_W'(2*SCK_DIV-1);

   tx_state_t              r_state;
   logic [CNT_W-1:0]       r_cnt;
   logic [3:0]             r_bit;
   logic                   r_hi;
   logic [FRAME_W-2:0]     r_sh;
   logic                   r_done;
   logic                   r_sck;
   logic                   r_cs;
   logic                   r_din;
   logic                   w_accept;

   assign w_accept = start && ((r_state == TX_IDLE) ||
                               ((r_state == TX_GAP) && (r_cnt == '0)));

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state <= TX_IDLE;
         r_cnt   <= '0;
         r_bit   <= '0;
         r_hi    <= 1'b0;
         r_sh    <= '0;
         r_done  <= 1'b0;
         r_sck   <= 1'b0;
         r_cs    <= 1'b1;
         r_din   <= 1'b0;
      end else begin
         // done marks the final gap cycle so the next frame can start without a hole
         r_done <= (r_state == TX_GAP) && (r_cnt == CNT_W'(1));
         if (w_accept) begin
            r_state <= TX_LOAD;
            r_cs    <= 1'b0;
            r_sck   <= 1'b0;
            r_din   <= frame[FRAME_W-1];
            r_sh    <= frame[FRAME_W-2:0];
         end else begin
            case (r_state)
               TX_LOAD: begin
                  r_state <= TX_SHIFT;
                  r_cnt   <= C_HALF;
                  r_hi    <= 1'b0;
                  r_bit   <= 4'd15;
               end
               TX_SHIFT: begin
                  if (r_cnt != '0) begin
                     r_cnt <= r_cnt - CNT_W'(1);
                  end else begin
                     r_cnt <= C_HALF;
                     if (!r_hi) begin
                        r_hi  <= 1'b1;
                        r_sck <= 1'b1;
                     end else begin
                        r_hi  <= 1'b0;
                        r_sck <= 1'b0;
                        if (r_bit == 4'd0) begin
                           r_state <= TX_HOLD;
                        end else begin
                           r_bit <= r_bit - 4'd1;
                           r_din <= r_sh[FRAME_W-2];
                           r_sh  <= {r_sh[FRAME_W-3:0], 1'b0};
                        end
                     end
                  end
               end
               TX_HOLD: begin
                  if (r_cnt != '0) begin
                     r_cnt <= r_cnt - CNT_W'(1);
                  end else begin
                     r_state <= TX_GAP;
                     r_cs    <= 1'b1;
                     r_cnt   <= C_GAP;
                  end
               end
               TX_GAP: begin
                  if (r_cnt != '0) r_cnt <= r_cnt - CNT_W'(1);
                  else             r_state <= TX_IDLE;
               end
               default: ;
            endcase
         end
      end
   end

   assign done    = r_done;
   assign max_sck = r_sck;
   assign max_cs  = r_cs;
   assign max_din = r_din;

endmodule

// File: rtl/max7219_display_driver.sv
// MAX7219 display driver: runs the device init sequence after reset, then
// refreshes all eight digit registers from a shadow copy of the inputs on
// every update request.
// Ports: clock/reset (sync, active high); digits/dp_mask/blank_mask form the
// display image; update requests a refresh; busy/init_done report status;
// max_sck/max_cs/max_din drive the device.
//
// state     | meaning
// S_INIT    | sending the 5 configuration frames
// S_REFRESH | sending the 8 digit frames from the shadow registers
// S_IDLE    | nothing to send, busy low
module max7219_display_driver
   import max7219_pkg::*;
#(
   parameter int         SCK_DIV   = 2,
   parameter logic [3:0] INTENSITY = 4'h8
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] digits,
   input  logic [7:0]  dp_mask,
   input  logic [7:0]  blank_mask,
   input  logic        update,
   output logic        busy,
   output logic        init_done,
   output logic        max_sck,
   output logic        max_cs,
   output logic        max_din
);

   seq_state_t         r_state;
   logic [3:0]         r_idx;
   logic               r_kick;
   logic               r_busy;
   logic               r_init_done;
   logic               r_pending;
   logic [31:0]        r_sh_digits;
   logic [7:0]         r_sh_dp;
   logic [7:0]         r_sh_blank;

   logic               w_tx_done;
   logic               w_last;
   logic               w_series_end;
   logic               w_restart;
   logic               w_start;
   logic [FRAME_W-1:0] w_frame;
   logic [2:0]         w_didx;
   logic [31:0]        w_digits;
   logic [7:0]         w_dp;
   logic [7:0]         w_blank;
   logic [3:0]         w_code;

   function automatic logic [FRAME_W-1:0] init_frame(input logic [2:0] idx);
      case (idx)
         3'd0:    return make_frame(REG_SHUTDOWN, 8'h01);
         3'd1:    return make_frame(REG_DECODE, 8'hFF);
         3'd2:    return make_frame(REG_SCANLIM, 8'h07);
         3'd3:    return make_frame(REG_INTENSITY, {4'h0, INTENSITY});
         default: return make_frame(REG_TEST, 8'h00);
      endcase
   endfunction

   // r_idx is the index of the next frame to hand to the transmitter
   assign w_last       = (r_idx == ((r_state == S_INIT) ? 4'd5 : 4'd8));
   assign w_series_end = w_tx_done && w_last;
   assign w_restart    = w_series_end && ((r_state == S_INIT) || r_pending || update);
   assign w_start      = r_kick || (w_tx_done && (!w_last || w_restart));

   // A chained refresh takes digit 0 straight from the live inputs, the same
   // values the shadow captures on that edge, so no idle cycle is inserted.
   always_comb begin
      w_digits = w_restart ? digits     : r_sh_digits;
      w_dp     = w_restart ? dp_mask    : r_sh_dp;
      w_blank  = w_restart ? blank_mask : r_sh_blank;
      w_didx   = w_restart ? 3'd0       : r_idx[2:0];
      w_code   = w_blank[w_didx] ? CB_BLANK : w_digits[{w_didx, 2'b00} +: 4];
      if ((r_state == S_INIT) && !w_restart)
         w_frame = init_frame(r_idx[2:0]);
      else
         w_frame = make_frame(REG_DIGIT0 + {1'b0, w_didx}, {w_dp[w_didx], 3'b000, w_code});
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state     <= S_INIT;
         r_idx       <= '0;
         r_kick      <= 1'b1;
         r_busy      <= 1'b1;
         r_init_done <= 1'b0;
         r_pending   <= 1'b0;
         r_sh_digits <= '0;
         r_sh_dp     <= '0;
         r_sh_blank  <= '0;
      end else begin
         r_kick <= 1'b0;
         if (w_start) r_idx <= r_idx + 4'd1;
         case (r_state)
            S_IDLE: begin
               if (update) begin
                  r_state     <= S_REFRESH;
                  r_busy      <= 1'b1;
                  r_idx       <= '0;
                  r_kick      <= 1'b1;
                  r_sh_digits <= digits;
                  r_sh_dp     <= dp_mask;
                  r_sh_blank  <= blank_mask;
               end
            end
            default: begin
               if (w_restart) begin
                  if (r_state == S_INIT) r_init_done <= 1'b1;
                  r_state     <= S_REFRESH;
                  r_idx       <= 4'd1;
                  r_pending   <= 1'b0;
                  r_sh_digits <= digits;
                  r_sh_dp     <= dp_mask;
                  r_sh_blank  <= blank_mask;
               end else if (w_series_end) begin
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
               end else if (update) begin
                  r_pending <= 1'b1;
               end
            end
         endcase
      end
   end

   max7219_spi_tx #(.SCK_DIV(SCK_DIV)) u_tx (
      .clock   (clock),
      .reset   (reset),
      .start   (w_start),
      .frame   (w_frame),
      .done    (w_tx_done),
      .max_sck (max_sck),
      .max_cs  (max_cs),
      .max_din (max_din)
   );

   assign busy      = r_busy;
   assign init_done = r_init_done;

endmodule
